interp_bracket_ctrl: RTL and testbench
======================================

// Module: interp_bracket_ctrl
// PURPOSE
//  Sequencer for the interpolation datapath. On start, it linearly scans the input
//  point BRAM (x list on port A, y list on port B, shared address) for the pair that
//  brackets a target x. It writes that pair to output BRAM: lower point at address 0,
//  upper at address 1. It sits between the x_select/busy/done top FSM and the two
//  dual-port BRAMs.
// PARAMETERS
//  ADDR_W    10    BRAM address width
//  DATA_W    16    x/y sample width (unsigned)
//  N_POINTS  1024  valid entries, indices 0..N_POINTS-1; x strictly ascending; 2..2**ADDR_W
// PORTS
//  CLK100MHZ  in   1       system clock; all logic on rising edge
//  reset      in   1       synchronous, active-high
//  start      in   1       1-cycle request; sampled only in IDLE
//  x_target   in   DATA_W  search value; latched when start is accepted
//  busy       out  1       high in every state except IDLE
//  done       out  1       1-cycle pulse; result written
//  clamped    out  1       last result out of range (held until next accepted start)
//  exact      out  1       last result hit x_target exactly (held until next accepted start)
//  in_addr    out  ADDR_W  registered; drives addra and addrb of input BRAM
//  in_x       in   DATA_W  input BRAM douta
//  in_y       in   DATA_W  input BRAM doutb
//  out_we     out  1       drives wea and web of output BRAM
//  out_addr   out  ADDR_W  output BRAM address (0 or 1)
//  out_x      out  DATA_W  drives dina
//  out_y      out  DATA_W  drives dinb
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; index 0; lo/hi/target regs 0.
//  The BRAM has 1-cycle read latency. in_addr is registered, so data is valid 2 cycles
//  after in_addr is loaded.
//  States:
//   IDLE:  start=1 -> latch x_target; idx<=0; clear clamped/exact; go to ISSUE.
//          start=0 -> stay.
//   ISSUE: in_addr<=idx; go to WAIT.
//   WAIT:  BRAM captures the address; go to CMP.
//   CMP:   sample in_x/in_y into cur; prev holds the previous cur. Decide:
//          in_x == tgt              -> lo=hi=cur; exact<=1.
//          in_x >  tgt, idx == 0    -> lo=hi=cur; clamped<=1.
//          in_x >  tgt, idx > 0     -> lo=prev; hi=cur.
//          in_x <  tgt, idx == N-1  -> lo=hi=cur; clamped<=1.
//          otherwise                -> idx<=idx+1; go to ISSUE.
//          A decided case goes to WR_LO.
//   WR_LO: out_we=1, out_addr=0, out_x/out_y=lo; go to WR_HI.
//   WR_HI: out_we=1, out_addr=1, data=hi; go to DONE.
//   DONE:  done=1 for one cycle; go to IDLE.
//  Timing: 3 cycles per element examined. If the hit is at index i, done is asserted
//  3*(i+1)+3 cycles after the edge that accepted start. Worst case is
//  3*N_POINTS+3 cycles.
//  out_we is high only in WR_LO and WR_HI. out_x/out_y/out_addr are don't-care when
//  out_we=0 but must not be X.
//  start while busy: ignored, with no queueing. x_target changes while busy: no effect.
//  reset in any state: next cycle is IDLE with all outputs 0. A WR_LO already done may
//  leave address 0 written; address 1 is not written.
//  Comparisons are unsigned, DATA_W wide. idx never exceeds N_POINTS-1, so it never wraps.
// CONFIGURATION
//  INTERP_ABORT_EN defined:
//   - Adds input port `abort` (1 bit, after start).
//   - abort=1 in any non-IDLE state -> IDLE next cycle; no done; no further writes.
//   - clamped/exact are cleared.
//   - abort in IDLE is ignored; abort has priority over every CMP decision.
//  INTERP_ABORT_EN undefined: port absent; a scan always runs to DONE unless reset.
// TESTING
//  1. Model x[i]=10*i, y[i]=100+i, N=1024; start with x_target=25 -> writes (20,102)
//     at addr 0 and (30,103) at addr 1; done 15 cycles after start; clamped=0, exact=0.
//  2. x_target=40 -> both addrs (40,104); exact=1; done at cycle 18.
//  3. x_target=0 with x[0]=5 -> both (5,100); clamped=1; done at cycle 6.
//     x_target=65535 -> both (10230,1123); clamped=1; done at cycle 3075.
//  4. start pulsed again during the scan with a different target -> ignored; result
//     matches the first target; exactly 2 writes.
//  5. reset asserted in WAIT of idx 2 -> next cycle busy=0, out_we=0, done never pulses;
//     a fresh start then completes normally.
//  6. (INTERP_ABORT_EN) abort in CMP of idx 3 with target 25 -> IDLE next cycle; zero
//     writes; no done.

Source files
------------

// File: rtl/interp_bracket_ctrl.sv
// Bracket-search sequencer: scans the input point BRAM for the pair around x_target
// and writes lower/upper points to output BRAM addresses 0/1. Optional abort: INTERP_ABORT_EN.
module interp_bracket_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 16,
  parameter int N_POINTS = 1024
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic              start,
`ifdef INTERP_ABORT_EN
  input  logic              abort,
`endif
  input  logic [DATA_W-1:0] x_target,
  output logic              busy,
  output logic              done,
  output logic              clamped,
  output logic              exact,
  output logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_y,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_x,
  output logic [DATA_W-1:0] out_y
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_POINTS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_CMP, S_WR_LO, S_WR_HI, S_DONE
  } state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_idx, r_in_addr;
  logic [DATA_W-1:0] r_tgt;
  logic [DATA_W-1:0] r_prev_x, r_prev_y, r_lo_x, r_lo_y, r_hi_x, r_hi_y;
  logic              r_done, r_clamped, r_exact;

  logic w_abort, w_eq, w_gt, w_first, w_last, w_decide, w_single, w_clamp;

`ifdef INTERP_ABORT_EN
  assign w_abort = abort && (r_state != S_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  // A point below target at the last index, or above target at index 0, is out of range.
  assign w_eq     = (in_x == r_tgt);
  assign w_gt     = (in_x > r_tgt);
  assign w_first  = (r_idx == '0);
  assign w_last   = (r_idx == LAST_IDX);
  assign w_clamp  = !w_eq && ((w_gt && w_first) || (!w_gt && w_last));
  assign w_single = w_eq || w_clamp;
  assign w_decide = w_eq || w_gt || w_last;

  always_ff @(posedge CLK100MHZ) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  w_next = S_CMP;
      S_CMP:   w_next = w_decide ? S_WR_LO : S_ISSUE;
      S_WR_LO: w_next = S_WR_HI;
      S_WR_HI: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_idx     <= '0;
      r_in_addr <= '0;
      r_tgt     <= '0;
      r_prev_x  <= '0;
      r_prev_y  <= '0;
      r_lo_x    <= '0;
      r_lo_y    <= '0;
      r_hi_x    <= '0;
      r_hi_y    <= '0;
      r_done    <= 1'b0;
      r_clamped <= 1'b0;
      r_exact   <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE) && !w_abort;
      if (w_abort) begin
        r_clamped <= 1'b0;
        r_exact   <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: if (start) begin
            r_tgt     <= x_target;
            r_idx     <= '0;
            r_clamped <= 1'b0;
            r_exact   <= 1'b0;
          end
          S_ISSUE: r_in_addr <= r_idx;
          S_CMP: begin
            r_prev_x <= in_x;
            r_prev_y <= in_y;
            if (w_decide) begin
              r_lo_x    <= w_single ? in_x : r_prev_x;
              r_lo_y    <= w_single ? in_y : r_prev_y;
              r_hi_x    <= in_x;
              r_hi_y    <= in_y;
              r_exact   <= w_eq;
              r_clamped <= w_clamp;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign clamped  = r_clamped;
  assign exact    = r_exact;
  assign in_addr  = r_in_addr;
  assign out_we   = ((r_state == S_WR_LO) || (r_state == S_WR_HI)) && !w_abort;
  assign out_addr = ADDR_W'(r_state == S_WR_HI);
  assign out_x    = (r_state == S_WR_HI) ? r_hi_x : r_lo_x;
  assign out_y    = (r_state == S_WR_HI) ? r_hi_y : r_lo_y;

endmodule

// File: tb/tb_interp_bracket_ctrl.sv
// Scoreboard bench for interp_bracket_ctrl: BRAM models, reference bracket search,
// expected writes queued at start and popped as out_we fires.
module tb_interp_bracket_ctrl;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
  localparam int N      = 1024;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [DATA_W-1:0] x_target = '0;
  logic              busy, done, clamped, exact, out_we;
  logic [ADDR_W-1:0] in_addr, out_addr;
  logic [DATA_W-1:0] in_x, in_y, out_x, out_y;
`ifdef INTERP_ABORT_EN
  logic              abort = 1'b0;
`endif

  always #5 clk = ~clk;

  interp_bracket_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_POINTS(N)) dut (
    .CLK100MHZ(clk), .reset(reset), .start(start),
`ifdef INTERP_ABORT_EN
    .abort(abort),
`endif
    .x_target(x_target), .busy(busy), .done(done), .clamped(clamped), .exact(exact),
    .in_addr(in_addr), .in_x(in_x), .in_y(in_y),
    .out_we(out_we), .out_addr(out_addr), .out_x(out_x), .out_y(out_y)
  );

  logic [DATA_W-1:0] x_mem [N];
  logic [DATA_W-1:0] y_mem [N];

  always @(posedge clk) begin
    in_x <= x_mem[in_addr];
    in_y <= y_mem[in_addr];
  end

  typedef struct {
    int addr;
    int x;
    int y;
  } wr_t;

  wr_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  n_writes = 0;
  int  n_done   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) n_done++;
    if (out_we === 1'b1) begin
      wr_t e;
      n_writes++;
      check("wr_expected", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("wr_addr", 32'(out_addr), e.addr);
        check("wr_x", 32'(out_x), e.x);
        check("wr_y", 32'(out_y), e.y);
      end
    end
  end

  // Reference search straight from the bracket rules.
  task automatic model(input int t, output int lo, output int hi, output bit cl,
                       output bit ex, output int idx);
    lo = 0; hi = 0; cl = 0; ex = 0; idx = N - 1;
    for (int i = 0; i < N; i++) begin
      int xi;
      xi = int'(x_mem[i]);
      if (xi == t) begin
        lo = i; hi = i; ex = 1; idx = i; return;
      end
      if (xi > t) begin
        idx = i; hi = i;
        if (i == 0) begin lo = i; cl = 1; end
        else lo = i - 1;
        return;
      end
      if (i == N - 1) begin lo = i; hi = i; cl = 1; end
    end
  endtask

  task automatic run_scan(input int t, input int disturb_t, input string tag);
    int lo, hi, idx, cyc, bound, w0, d0;
    bit cl, ex;
    wr_t e;
    model(t, lo, hi, cl, ex, idx);
    e.addr = 0; e.x = int'(x_mem[lo]); e.y = int'(y_mem[lo]); sb_q.push_back(e);
    e.addr = 1; e.x = int'(x_mem[hi]); e.y = int'(y_mem[hi]); sb_q.push_back(e);
    w0 = n_writes; d0 = n_done;
    @(negedge clk);
    x_target = DATA_W'(t);
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    cyc = 0;
    bound = 3 * N + 20;
    while (done !== 1'b1 && cyc < bound) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (disturb_t >= 0 && cyc == 4) begin
        start    = 1'b1;
        x_target = DATA_W'(disturb_t);
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(3 * (idx + 1) + 3));
    check({tag, "_clamped"}, 32'(clamped), 32'(cl));
    check({tag, "_exact"}, 32'(exact), 32'(ex));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_nwrites"}, 32'(n_writes - w0), 32'd2);
    check({tag, "_ndone"}, 32'(n_done - d0), 32'd1);
    check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int w0, d0;
    for (int i = 0; i < N; i++) begin
      x_mem[i] = DATA_W'(10 * i);
      y_mem[i] = DATA_W'(100 + i);
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_clamped", 32'(clamped), 32'd0);
    check("rst_exact", 32'(exact), 32'd0);
    check("rst_out_we", 32'(out_we), 32'd0);
    check("rst_in_addr", 32'(in_addr), 32'd0);
    check("rst_out_x", 32'(out_x), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_scan(25, -1, "t25");
    run_scan(40, -1, "t40");
    x_mem[0] = 16'd5;
    run_scan(0, -1, "t0");
    x_mem[0] = 16'd0;
    run_scan(0, -1, "t0_exact");
    run_scan(65535, -1, "tmax");
    run_scan(25, 900, "ign_start");
    run_scan(1003, -1, "t1003");

    // Reset in WAIT of index 2.
    w0 = n_writes; d0 = n_done;
    @(negedge clk);
    x_target = 16'd25;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("rstmid_in_addr", 32'(in_addr), 32'd2);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_out_we", 32'(out_we), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    check("rstmid_in_addr0", 32'(in_addr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("rstmid_nwrites", 32'(n_writes - w0), 32'd0);
    check("rstmid_ndone", 32'(n_done - d0), 32'd0);
    run_scan(40, -1, "after_rst");

`ifdef INTERP_ABORT_EN
    // Abort in CMP of index 3, where target 25 would have been decided.
    w0 = n_writes; d0 = n_done;
    @(negedge clk);
    x_target = 16'd25;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    check("abort_out_we", 32'(out_we), 32'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_clamped", 32'(clamped), 32'd0);
    check("abort_exact", 32'(exact), 32'd0);
    repeat (30) @(negedge clk);
    check("abort_nwrites", 32'(n_writes - w0), 32'd0);
    check("abort_ndone", 32'(n_done - d0), 32'd0);
    run_scan(25, -1, "after_abort");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
